// File: rtl/display_pkg.sv
// Shared display-domain definitions: Midas power-sequencer states and
// default panel timing for a 40 MHz display clock.
package display_pkg;

    typedef enum logic [3:0] {
        ST_OFF         = 4'd0,
        ST_EN_WAIT     = 4'd1,
        ST_BLANK_UP    = 4'd2,
        ST_BL_ON_WAIT  = 4'd3,
        ST_ON          = 4'd4,
        ST_BL_OFF_WAIT = 4'd5,
        ST_BLANK_DN    = 4'd6,
        ST_OFF_HOLD    = 4'd7,
        ST_FAULT       = 4'd8
    } pwr_state_t;

    localparam int unsigned DEF_T_EN_CYCLES      = 4000;
    localparam int unsigned DEF_BLANK_FRAMES     = 2;
    localparam int unsigned DEF_T_BL_ON_CYCLES   = 400000;
    localparam int unsigned DEF_T_BL_OFF_CYCLES  = 400000;
    localparam int unsigned DEF_T_OFF_MIN_CYCLES = 4000000;
    localparam bit          DEF_VSYNC_ACTIVE_LOW = 1'b1;
    localparam int unsigned DEF_CNT_W            = 26;

    // A requested length of zero behaves as one.
    function automatic int unsigned at_least_one(input int unsigned n);
        return (n == 0) ? 1 : n;
    endfunction

endpackage

// File: rtl/midas_power_sequencer_edge_detect.sv
// Registered active-edge detector for vsync-style strobes; the pulse lags
// the input edge by one clock and honours the configured polarity.
module edge_detect #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic pulse
);

    logic sig_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sig_q <= ACTIVE_LOW;
            pulse <= 1'b0;
        end else begin
            sig_q <= sig_in;
            pulse <= (sig_in ^ ACTIVE_LOW) & ~(sig_q ^ ACTIVE_LOW);
        end
    end

endmodule

// File: rtl/midas_power_sequencer.sv
// Midas RGB panel power sequencer: orders disp_en, video_en and backlight_en.
// Define MIDAS_PWR_WATCHDOG_EN to add the missing-vsync watchdog and FAULT state.
module midas_power_sequencer
    import display_pkg::*;
#(
    parameter int unsigned T_EN_CYCLES      = DEF_T_EN_CYCLES,
    parameter int unsigned BLANK_FRAMES     = DEF_BLANK_FRAMES,
    parameter int unsigned T_BL_ON_CYCLES   = DEF_T_BL_ON_CYCLES,
    parameter int unsigned T_BL_OFF_CYCLES  = DEF_T_BL_OFF_CYCLES,
    parameter int unsigned T_OFF_MIN_CYCLES = DEF_T_OFF_MIN_CYCLES,
    parameter bit          VSYNC_ACTIVE_LOW = DEF_VSYNC_ACTIVE_LOW,
    parameter int unsigned CNT_W            = DEF_CNT_W
) (
    input  logic       clk_display,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_on,
    input  logic       vsync_in,
    output logic       disp_en,
    output logic       video_en,
    output logic       backlight_en,
    output logic       panel_on,
    output logic [3:0] state_o,
    output logic       fault
);

    localparam int unsigned EN_N = at_least_one(T_EN_CYCLES);
    localparam logic [CNT_W-1:0] EN_LAST     = CNT_W'(EN_N - 1);
    localparam logic [CNT_W-1:0] FR_LAST     = CNT_W'(at_least_one(BLANK_FRAMES) - 1);
    localparam logic [CNT_W-1:0] BL_ON_LAST  = CNT_W'(at_least_one(T_BL_ON_CYCLES) - 1);
    localparam logic [CNT_W-1:0] BL_OFF_END  = CNT_W'(at_least_one(T_BL_OFF_CYCLES));
    localparam logic [CNT_W-1:0] OFF_LAST    = CNT_W'(at_least_one(T_OFF_MIN_CYCLES) - 1);

    pwr_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             tick;
    logic             accept;
    logic             recover;
    logic             cmd_ready_n, disp_en_n, video_en_n, backlight_en_n;

    edge_detect #(
        .ACTIVE_LOW(VSYNC_ACTIVE_LOW)
    ) u_vsync_edge (
        .clk    (clk_display),
        .reset  (reset),
        .sig_in (vsync_in),
        .pulse  (tick)
    );

`ifdef MIDAS_PWR_WATCHDOG_EN
    localparam int unsigned WD_LIMIT = 4 * EN_N * 256;
    localparam int unsigned WD_W     = $clog2(WD_LIMIT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LIMIT - 1);

    logic [WD_W-1:0] wd_cnt, wd_next;
    logic            wd_watch;
    logic            fault_n;
`endif

    assign accept  = cmd_valid & cmd_ready;
    assign state_o = state;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        recover    = 1'b0;
`ifdef MIDAS_PWR_WATCHDOG_EN
        wd_watch   = 1'b0;
        wd_next    = '0;
`endif
        case (state)
            ST_OFF: begin
                if (accept && cmd_on) state_next = ST_EN_WAIT;
            end
            ST_EN_WAIT: begin
                if (cnt == EN_LAST) state_next = ST_BLANK_UP;
                else                cnt_next   = cnt + CNT_W'(1);
            end
            ST_BLANK_UP: begin
`ifdef MIDAS_PWR_WATCHDOG_EN
                wd_watch = 1'b1;
`endif
                if (tick) begin
                    if (cnt == FR_LAST) state_next = ST_BL_ON_WAIT;
                    else                cnt_next   = cnt + CNT_W'(1);
                end
            end
            ST_BL_ON_WAIT: begin
                if (cnt == BL_ON_LAST) state_next = ST_ON;
                else                   cnt_next   = cnt + CNT_W'(1);
            end
            ST_ON: begin
                if (accept && !cmd_on) state_next = ST_BL_OFF_WAIT;
            end
            // Counter parks at the full delay; only then is a frame tick honoured.
            ST_BL_OFF_WAIT: begin
                if (cnt != BL_OFF_END) begin
                    cnt_next = cnt + CNT_W'(1);
                end else begin
`ifdef MIDAS_PWR_WATCHDOG_EN
                    wd_watch = 1'b1;
`endif
                    if (tick) state_next = ST_BLANK_DN;
                end
            end
            ST_BLANK_DN: begin
`ifdef MIDAS_PWR_WATCHDOG_EN
                wd_watch = 1'b1;
`endif
                if (tick) begin
                    if (cnt == FR_LAST) state_next = ST_OFF_HOLD;
                    else                cnt_next   = cnt + CNT_W'(1);
                end
            end
            ST_OFF_HOLD: begin
                if (cnt == OFF_LAST) state_next = ST_OFF;
                else                 cnt_next   = cnt + CNT_W'(1);
            end
`ifdef MIDAS_PWR_WATCHDOG_EN
            ST_FAULT: begin
                if (accept && !cmd_on) state_next = ST_OFF_HOLD;
            end
`endif
            default: begin
                state_next = ST_OFF;
                recover    = 1'b1;
            end
        endcase

`ifdef MIDAS_PWR_WATCHDOG_EN
        if (wd_watch && !tick) begin
            if (wd_cnt == WD_LAST) state_next = ST_FAULT;
            else                   wd_next    = wd_cnt + WD_W'(1);
        end
`endif

        if (state_next != state) begin
            cnt_next = '0;
`ifdef MIDAS_PWR_WATCHDOG_EN
            wd_next  = '0;
`endif
        end

        // Outputs are decoded from the next state so they register in step with it.
        disp_en_n      = !recover && (state_next inside {ST_EN_WAIT, ST_BLANK_UP, ST_BL_ON_WAIT,
                                                         ST_ON, ST_BL_OFF_WAIT, ST_BLANK_DN});
        video_en_n     = !recover && (state_next inside {ST_BL_ON_WAIT, ST_ON, ST_BL_OFF_WAIT});
        backlight_en_n = !recover && (state_next == ST_ON);
`ifdef MIDAS_PWR_WATCHDOG_EN
        cmd_ready_n    = !recover && (state_next inside {ST_OFF, ST_ON, ST_FAULT});
        fault_n        = !recover && (state_next == ST_FAULT);
`else
        cmd_ready_n    = !recover && (state_next inside {ST_OFF, ST_ON});
`endif
    end

    always_ff @(posedge clk_display) begin
        if (reset) begin
            state        <= ST_OFF;
            cnt          <= '0;
            cmd_ready    <= 1'b0;
            disp_en      <= 1'b0;
            video_en     <= 1'b0;
            backlight_en <= 1'b0;
            panel_on     <= 1'b0;
`ifdef MIDAS_PWR_WATCHDOG_EN
            wd_cnt       <= '0;
            fault        <= 1'b0;
`endif
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            cmd_ready    <= cmd_ready_n;
            disp_en      <= disp_en_n;
            video_en     <= video_en_n;
            backlight_en <= backlight_en_n;
            panel_on     <= backlight_en_n;
`ifdef MIDAS_PWR_WATCHDOG_EN
            wd_cnt       <= wd_next;
            fault        <= fault_n;
`endif
        end
    end

`ifndef MIDAS_PWR_WATCHDOG_EN
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_midas_power_sequencer.sv
// Directed bench for midas_power_sequencer with short timing parameters;
// the watchdog sequence runs only when MIDAS_PWR_WATCHDOG_EN is defined.
module tb_midas_power_sequencer;
    import display_pkg::*;

    logic       clk_display = 1'b0;
    logic       reset       = 1'b1;
    logic       cmd_valid   = 1'b0;
    logic       cmd_on      = 1'b0;
    logic       vsync_in    = 1'b1;
    logic       cmd_ready, disp_en, video_en, backlight_en, panel_on, fault;
    logic [3:0] state_o;

    int unsigned cyc    = 0;
    bit          vs_run = 1'b0;
    int          n_checks = 0;
    int          n_fail   = 0;

    midas_power_sequencer #(
        .T_EN_CYCLES      (4),
        .BLANK_FRAMES     (2),
        .T_BL_ON_CYCLES   (8),
        .T_BL_OFF_CYCLES  (8),
        .T_OFF_MIN_CYCLES (16),
        .VSYNC_ACTIVE_LOW (1'b1),
        .CNT_W            (26)
    ) dut (
        .clk_display  (clk_display),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_on       (cmd_on),
        .vsync_in     (vsync_in),
        .disp_en      (disp_en),
        .video_en     (video_en),
        .backlight_en (backlight_en),
        .panel_on     (panel_on),
        .state_o      (state_o),
        .fault        (fault)
    );

    always #5 clk_display = ~clk_display;

    typedef struct {
        logic       rst;
        logic       valid;
        logic       on;
        logic       ready;
        logic       disp;
        logic       video;
        logic       bl;
        logic       pon;
        logic [3:0] st;
    } vec_t;

    vec_t vecs [9];

    // Advance one clock; vsync is active low for 5 of every 50 cycles.
    task automatic step();
        @(posedge clk_display);
        #1;
        cyc++;
        vsync_in = (vs_run && (cyc % 50) < 5) ? 1'b0 : 1'b1;
    endtask

    task automatic run_to(input int unsigned target);
        while (cyc < target) step();
    endtask

    task automatic align(input int unsigned phase);
        while ((cyc % 50) != phase) step();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        int unsigned c0, c1, c2;
`ifdef MIDAS_PWR_WATCHDOG_EN
        int unsigned c3, c4;
`endif
        //            rst   vld   on    rdy   disp  vid   bl    pon   state
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ST_OFF};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ST_OFF};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ST_OFF};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ST_OFF};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ST_EN_WAIT};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ST_EN_WAIT};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ST_EN_WAIT};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ST_OFF};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ST_OFF};

        for (int i = 0; i < 9; i++) begin
            reset     = vecs[i].rst;
            cmd_valid = vecs[i].valid;
            cmd_on    = vecs[i].on;
            step();
            chk($sformatf("v%0d_ready", i), 32'(cmd_ready),    32'(vecs[i].ready));
            chk($sformatf("v%0d_disp", i),  32'(disp_en),      32'(vecs[i].disp));
            chk($sformatf("v%0d_video", i), 32'(video_en),     32'(vecs[i].video));
            chk($sformatf("v%0d_bl", i),    32'(backlight_en), 32'(vecs[i].bl));
            chk($sformatf("v%0d_pon", i),   32'(panel_on),     32'(vecs[i].pon));
            chk($sformatf("v%0d_state", i), 32'(state_o),      32'(vecs[i].st));
            chk($sformatf("v%0d_fault", i), 32'(fault),        32'd0);
        end
        cmd_valid = 1'b0;
        vs_run    = 1'b1;

        // Power-up; first frame tick lands in the BLANK_UP entry cycle.
        align(46);
        c0 = cyc;
        cmd_valid = 1'b1; cmd_on = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("up_disp_en", 32'(disp_en), 32'd1);
        chk("up_ready_low", 32'(cmd_ready), 32'd0);
        chk("up_state_en_wait", 32'(state_o), 32'(ST_EN_WAIT));
        run_to(c0 + 55);
        chk("up_video_before", 32'(video_en), 32'd0);
        step();
        chk("up_video_rise", 32'(video_en), 32'd1);
        chk("up_state_bl_on_wait", 32'(state_o), 32'(ST_BL_ON_WAIT));
        run_to(c0 + 63);
        chk("up_bl_before", 32'(backlight_en), 32'd0);
        step();
        chk("up_bl_rise", 32'(backlight_en), 32'd1);
        chk("up_panel_on", 32'(panel_on), 32'd1);
        chk("up_ready_on", 32'(cmd_ready), 32'd1);
        chk("up_state_on", 32'(state_o), 32'(ST_ON));

        // Redundant on while ON.
        cmd_valid = 1'b1; cmd_on = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("redund_on_ready", 32'(cmd_ready), 32'd1);
        chk("redund_on_state", 32'(state_o), 32'(ST_ON));
        chk("redund_on_bl", 32'(backlight_en), 32'd1);
        step();
        chk("redund_on_video", 32'(video_en), 32'd1);

        // Power-down; tick arrives in the first cycle after the 8-cycle wait.
        align(42);
        c1 = cyc;
        cmd_valid = 1'b1; cmd_on = 1'b0;
        step();
        cmd_valid = 1'b0;
        chk("dn_bl_fall", 32'(backlight_en), 32'd0);
        chk("dn_panel_off", 32'(panel_on), 32'd0);
        chk("dn_video_held", 32'(video_en), 32'd1);
        chk("dn_ready_low", 32'(cmd_ready), 32'd0);
        run_to(c1 + 9);
        chk("dn_video_before", 32'(video_en), 32'd1);
        step();
        chk("dn_video_fall", 32'(video_en), 32'd0);
        chk("dn_state_blank_dn", 32'(state_o), 32'(ST_BLANK_DN));
        run_to(c1 + 109);
        chk("dn_disp_before", 32'(disp_en), 32'd1);
        step();
        chk("dn_disp_fall", 32'(disp_en), 32'd0);
        chk("dn_state_off_hold", 32'(state_o), 32'(ST_OFF_HOLD));

        // On request held through OFF_HOLD is only taken once ready rises.
        cmd_valid = 1'b1; cmd_on = 1'b1;
        run_to(c1 + 125);
        chk("hold_ready_low", 32'(cmd_ready), 32'd0);
        chk("hold_disp_low", 32'(disp_en), 32'd0);
        step();
        chk("hold_ready_rise", 32'(cmd_ready), 32'd1);
        chk("hold_state_off", 32'(state_o), 32'(ST_OFF));
        step();
        cmd_valid = 1'b0;
        chk("hold_accept_disp", 32'(disp_en), 32'd1);
        chk("hold_accept_state", 32'(state_o), 32'(ST_EN_WAIT));
        c2 = c1 + 126;

        // Reset in BL_ON_WAIT forces immediate all-off.
        run_to(c2 + 83);
        chk("rst_video_before", 32'(video_en), 32'd0);
        step();
        chk("rst_in_bl_on_wait", 32'(state_o), 32'(ST_BL_ON_WAIT));
        run_to(c2 + 86);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_disp", 32'(disp_en), 32'd0);
        chk("rst_video", 32'(video_en), 32'd0);
        chk("rst_bl", 32'(backlight_en), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_state", 32'(state_o), 32'(ST_OFF));
        step();
        chk("rst_ready_after", 32'(cmd_ready), 32'd1);
        chk("rst_state_after", 32'(state_o), 32'(ST_OFF));

`ifdef MIDAS_PWR_WATCHDOG_EN
        // vsync stuck inactive: watchdog expires 4096 cycles into BLANK_UP.
        vs_run = 1'b0;
        c3 = cyc;
        cmd_valid = 1'b1; cmd_on = 1'b1;
        step();
        cmd_valid = 1'b0;
        run_to(c3 + 4100);
        chk("wd_fault_before", 32'(fault), 32'd0);
        chk("wd_state_before", 32'(state_o), 32'(ST_BLANK_UP));
        step();
        chk("wd_fault", 32'(fault), 32'd1);
        chk("wd_disp", 32'(disp_en), 32'd0);
        chk("wd_ready", 32'(cmd_ready), 32'd1);
        chk("wd_state", 32'(state_o), 32'(ST_FAULT));
        cmd_valid = 1'b1; cmd_on = 1'b1;
        step();
        chk("wd_on_noop", 32'(state_o), 32'(ST_FAULT));
        c4 = cyc;
        cmd_on = 1'b0;
        step();
        cmd_valid = 1'b0;
        chk("wd_clear_fault", 32'(fault), 32'd0);
        chk("wd_clear_state", 32'(state_o), 32'(ST_OFF_HOLD));
        run_to(c4 + 16);
        chk("wd_hold_ready", 32'(cmd_ready), 32'd0);
        step();
        chk("wd_off_ready", 32'(cmd_ready), 32'd1);
        chk("wd_off_state", 32'(state_o), 32'(ST_OFF));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
